seq_compare: RTL and testbench

- Parametrised, multi-cycle magnitude comparator; the next generation of the ALU's single-bit less-than slice.
- Compares two WIDTH-bit operands, DIGIT bits per cycle, scanning from the most significant digit down.
- Signed or unsigned mode is selected per transaction. Produces registered one-hot lt/eq/gt.
- Sits beside the ALU for SLT/SLTU and branch compares; valid/ready handshake on both sides.

---
 rtl/seq_compare_pkg.sv | 18 +
 rtl/seq_compare_if.sv | 29 ++
 rtl/seq_compare_cmp_chunk.sv | 15 +
 rtl/seq_compare.sv | 125 ++++++++++++
 tb/tb_seq_compare.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/seq_compare_pkg.sv
// Shared encodings for the sequential magnitude comparator: FSM states,
// result bit positions and a small index-width helper.
package seq_compare_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int RES_LT = 0;
  localparam int RES_EQ = 1;
  localparam int RES_GT = 2;

  // Chunk index needs at least one bit even when there is a single chunk.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_compare_if.sv
// Operand/result handshake bundle for seq_compare; master is the ALU side,
// slave is the comparator.
interface seq_compare_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             lt;
  logic             eq;
  logic             gt;
  logic             busy;

  modport master (
    output in_valid, op_a, op_b, is_signed, out_ready,
    input  in_ready, out_valid, lt, eq, gt, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, is_signed, out_ready,
    output in_ready, out_valid, lt, eq, gt, busy
  );

endinterface

// File: rtl/seq_compare_cmp_chunk.sv
// Combinational DIGIT-bit unsigned compare; with DIGIT=1 this is the ALU's
// original single-bit less-than slice.
module seq_compare_cmp_chunk #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             chunk_lt,
  output logic             chunk_eq
);

  assign chunk_lt = (a < b);
  assign chunk_eq = (a == b);

endmodule

// File: rtl/seq_compare.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, signed or unsigned per op.
// Optional build macro SEQ_COMPARE_EARLY_EXIT_EN: leave SCAN on the first differing chunk.
module seq_compare
  import seq_compare_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic          clock,
  input  logic          reset,
  seq_compare_if.slave  bus
);

  localparam int NCHUNK = WIDTH / DIGIT;
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0]    LAST     = IW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  generate
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
      $error("seq_compare: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IW-1:0]    idx;
  logic             decided;
  logic [2:0]       res;

  logic [DIGIT-1:0] a_cur;
  logic [DIGIT-1:0] b_cur;
  logic             chunk_lt;
  logic             chunk_eq;
  logic             hit;
  logic             last;
  logic             scan_end;

  generate
    if (NCHUNK == 1) begin : g_one_chunk
      assign a_cur = a_r;
      assign b_cur = b_r;
    end else begin : g_chunks
      logic [DIGIT-1:0] a_ch [NCHUNK];
      logic [DIGIT-1:0] b_ch [NCHUNK];
      for (genvar i = 0; i < NCHUNK; i++) begin : g_slice
        assign a_ch[i] = a_r[i*DIGIT +: DIGIT];
        assign b_ch[i] = b_r[i*DIGIT +: DIGIT];
      end
      assign a_cur = a_ch[idx];
      assign b_cur = b_ch[idx];
    end
  endgenerate

  seq_compare_cmp_chunk #(.DIGIT(DIGIT)) u_cmp (
    .a        (a_cur),
    .b        (b_cur),
    .chunk_lt (chunk_lt),
    .chunk_eq (chunk_eq)
  );

  // Only the most significant differing chunk decides; later chunks are don't-care.
  assign hit  = !decided && !chunk_eq;
  assign last = (idx == '0);

`ifdef SEQ_COMPARE_EARLY_EXIT_EN
  assign scan_end = last || hit;
`else
  assign scan_end = last;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      idx     <= '0;
      decided <= 1'b0;
      res     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            // MSB flip maps two's-complement order onto unsigned order.
            a_r     <= bus.op_a ^ ({WIDTH{bus.is_signed}} & MSB_MASK);
            b_r     <= bus.op_b ^ ({WIDTH{bus.is_signed}} & MSB_MASK);
            idx     <= LAST;
            decided <= 1'b0;
            res     <= '0;
            state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (hit) begin
            res[RES_LT] <= chunk_lt;
            res[RES_GT] <= !chunk_lt;
            decided     <= 1'b1;
          end else if (last && !decided) begin
            res[RES_EQ] <= 1'b1;
          end
          if (scan_end) begin
            state <= ST_DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.lt        = res[RES_LT];
  assign bus.eq        = res[RES_EQ];
  assign bus.gt        = res[RES_GT];

endmodule

// File: tb/tb_seq_compare.sv
// Directed bench for seq_compare: default DIGIT=8 instance plus DIGIT=1/4/32 sweep instances.
module tb_seq_compare;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

`ifdef SEQ_COMPARE_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  localparam logic [2:0] R_LT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;

  seq_compare_if #(.WIDTH(32)) bus ();
  seq_compare_if #(.WIDTH(32)) sw1 ();
  seq_compare_if #(.WIDTH(32)) sw4 ();
  seq_compare_if #(.WIDTH(32)) sw32 ();

  seq_compare #(.WIDTH(32), .DIGIT(8))  dut    (.clock(clock), .reset(reset), .bus(bus));
  seq_compare #(.WIDTH(32), .DIGIT(1))  dut_d1 (.clock(clock), .reset(reset), .bus(sw1));
  seq_compare #(.WIDTH(32), .DIGIT(4))  dut_d4 (.clock(clock), .reset(reset), .bus(sw4));
  seq_compare #(.WIDTH(32), .DIGIT(32)) dut_d32 (.clock(clock), .reset(reset), .bus(sw32));

  logic        sw_valid = 1'b0;
  logic        sw_ready = 1'b0;
  logic        sw_signed = 1'b0;
  logic [31:0] sw_a = '0;
  logic [31:0] sw_b = '0;

  assign sw1.in_valid  = sw_valid;  assign sw1.out_ready  = sw_ready;
  assign sw1.op_a      = sw_a;      assign sw1.op_b       = sw_b;
  assign sw1.is_signed = sw_signed;
  assign sw4.in_valid  = sw_valid;  assign sw4.out_ready  = sw_ready;
  assign sw4.op_a      = sw_a;      assign sw4.op_b       = sw_b;
  assign sw4.is_signed = sw_signed;
  assign sw32.in_valid  = sw_valid; assign sw32.out_ready = sw_ready;
  assign sw32.op_a      = sw_a;     assign sw32.op_b      = sw_b;
  assign sw32.is_signed = sw_signed;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] main_res();
    return {bus.lt, bus.eq, bus.gt};
  endfunction

  // Launch one op on the main instance at a negedge; returns at the negedge after the accept edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    int guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    bus.op_a = a;
    bus.op_b = b;
    bus.is_signed = s;
    bus.in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run_cmp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [2:0] exp_res, input int exp_lat);
    int lat;
    chk({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
    launch(a, b, s);
    chk({tag, "/cleared"}, 32'(main_res()), 32'd0);
    wait_done(lat);
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/result"}, 32'(main_res()), 32'(exp_res));
    chk({tag, "/rdy_busy"}, {30'd0, bus.in_ready, bus.busy}, 32'b01);
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    chk({tag, "/retire"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
  endtask

  task automatic sweep_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] exp_res, input int e1, input int e4, input int e32);
    int l1 = -1;
    int l4 = -1;
    int l32 = -1;
    sw_a = a;
    sw_b = b;
    sw_signed = 1'b0;
    sw_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    sw_valid = 1'b0;
    for (int c = 0; c < 48; c++) begin
      if (sw1.out_valid  && l1  < 0) l1  = c;
      if (sw4.out_valid  && l4  < 0) l4  = c;
      if (sw32.out_valid && l32 < 0) l32 = c;
      if (l1 >= 0 && l4 >= 0 && l32 >= 0) break;
      @(negedge clock);
    end
    chk({tag, "/d1_lat"},  32'(l1),  32'(e1));
    chk({tag, "/d4_lat"},  32'(l4),  32'(e4));
    chk({tag, "/d32_lat"}, 32'(l32), 32'(e32));
    chk({tag, "/d1_res"},  32'({sw1.lt, sw1.eq, sw1.gt}),    32'(exp_res));
    chk({tag, "/d4_res"},  32'({sw4.lt, sw4.eq, sw4.gt}),    32'(exp_res));
    chk({tag, "/d32_res"}, 32'({sw32.lt, sw32.eq, sw32.gt}), 32'(exp_res));
    sw_ready = 1'b1;
    @(negedge clock);
    sw_ready = 1'b0;
  endtask

  initial begin
    int lat;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.is_signed = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    chk("reset/out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset/result",    32'(main_res()),    32'd0);
    chk("reset/busy",      32'(bus.busy),      32'd0);
    chk("reset/in_ready",  32'(bus.in_ready),  32'd1);

    run_cmp("u_5_7",       32'h0000_0005, 32'h0000_0007, 1'b0, R_LT, 4);
    run_cmp("s_m1_1",      32'hFFFF_FFFF, 32'h0000_0001, 1'b1, R_LT, EE ? 1 : 4);
    run_cmp("u_m1_1",      32'hFFFF_FFFF, 32'h0000_0001, 1'b0, R_GT, EE ? 1 : 4);
    run_cmp("u_msb_0",     32'h8000_0000, 32'h0000_0000, 1'b0, R_GT, EE ? 1 : 4);
    run_cmp("eq_1234",     32'h1234_5678, 32'h1234_5678, 1'b0, R_EQ, 4);
    run_cmp("s_min_max",   32'h8000_0000, 32'h7FFF_FFFF, 1'b1, R_LT, EE ? 1 : 4);
    run_cmp("u_min_max",   32'h8000_0000, 32'h7FFF_FFFF, 1'b0, R_GT, EE ? 1 : 4);

    // Backpressure: result must hold and a new operand pulse must be ignored.
    launch(32'h0000_0010, 32'h0000_0020, 1'b0);
    wait_done(lat);
    chk("bp/latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      chk("bp/hold", {27'd0, bus.out_valid, bus.in_ready, main_res()}, {27'd0, 2'b10, R_LT});
      if (i == 3) begin
        bus.op_a = 32'hFFFF_0000;
        bus.op_b = 32'h0000_0000;
        bus.in_valid = 1'b1;
      end
      if (i == 4) bus.in_valid = 1'b0;
      @(negedge clock);
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    chk("bp/idle", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
    run_cmp("bp_next", 32'h0000_0001, 32'h0000_0001, 1'b0, R_EQ, 4);

    // Reset two cycles into a four-chunk scan.
    launch(32'h0000_0005, 32'h0000_0007, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_mid/out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid/result",    32'(main_res()),    32'd0);
    chk("rst_mid/in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_mid/busy",      32'(bus.busy),      32'd0);
    run_cmp("rst_next", 32'h0000_0100, 32'h0000_00FF, 1'b0, R_GT, EE ? 3 : 4);

    sweep_run("sw_eq",  32'h1234_5678, 32'h1234_5678, R_EQ, 32, 8, 1);
    sweep_run("sw_msb", 32'h8000_0000, 32'h0000_0000, R_GT, EE ? 1 : 32, EE ? 1 : 8, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
